// File: rtl/md_unit_pkg.sv
// Shared opcode/state definitions and the divide helper for the EX-stage multiply/divide unit.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Returns {remainder, quotient}; signed mode truncates toward zero and the
  // remainder follows the dividend's sign. Working on magnitudes makes
  // 0x80000000 / -1 wrap to 0x80000000 with remainder 0.
  function automatic logic [63:0] md_divide(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        sgn);
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) begin
      return 64'd0;
    end
    if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      ua = a[31] ? (32'd0 - a) : a;
      ub = b[31] ? (32'd0 - b) : b;
      q  = ua / ub;
      r  = ua % ub;
      if (a[31] ^ b[31]) q = 32'd0 - q;
      if (a[31])         r = 32'd0 - r;
    end
    return {r, q};
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: owns HI/LO, holds results pending until the
// busy countdown expires, then commits them in one step.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  mdctr,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdout
);

  md_state_e   state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] phi, plo, phi_n, plo_n;
  logic [31:0] hi_n, lo_n;
  logic        pwrite, pwrite_n;
  logic [63:0] prod_s, prod_u;
  md_op_e      op;

  assign op     = md_op_e'(mdctr);
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign busy   = (state == MD_RUN);

  always_comb begin
    case (op)
      MD_MFHI: mdout = hi;
      MD_MFLO: mdout = lo;
      default: mdout = 32'd0;
    endcase
  end

  // Next-state: issue computes the result up front; RUN only counts down and
  // commits. A divide by zero still runs but leaves pwrite low so HI/LO stay put.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    phi_n    = phi;
    plo_n    = plo;
    pwrite_n = pwrite;
    hi_n     = hi;
    lo_n     = lo;
    case (state)
      MD_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT: begin
              {phi_n, plo_n} = prod_s;
              pwrite_n       = 1'b1;
              cnt_n          = 16'(MULT_CYCLES);
              state_n        = MD_RUN;
            end
            MD_MULTU: begin
              {phi_n, plo_n} = prod_u;
              pwrite_n       = 1'b1;
              cnt_n          = 16'(MULT_CYCLES);
              state_n        = MD_RUN;
            end
            MD_DIV: begin
              {phi_n, plo_n} = md_divide(A, B, 1'b1);
              pwrite_n       = (B != 32'd0);
              cnt_n          = 16'(DIV_CYCLES);
              state_n        = MD_RUN;
            end
            MD_DIVU: begin
              {phi_n, plo_n} = md_divide(A, B, 1'b0);
              pwrite_n       = (B != 32'd0);
              cnt_n          = 16'(DIV_CYCLES);
              state_n        = MD_RUN;
            end
            MD_MTHI: hi_n = A;
            MD_MTLO: lo_n = A;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        cnt_n = cnt - 16'd1;
        if (cnt == 16'd1) begin
          state_n  = MD_IDLE;
          pwrite_n = 1'b0;
          if (pwrite) begin
            hi_n = phi;
            lo_n = plo;
          end
        end
      end
      default: state_n = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= MD_IDLE;
      cnt    <= 16'd0;
      phi    <= 32'd0;
      plo    <= 32'd0;
      pwrite <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      phi    <= phi_n;
      plo    <= plo_n;
      pwrite <= pwrite_n;
      hi     <= hi_n;
      lo     <= lo_n;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: issued operations push expected HI/LO and busy
// length; a monitor pops and checks them whenever busy falls.
module tb_md_unit;
  import md_unit_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  mdctr;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo, mdout;

  exp_t sbQueue[$];
  int   checks = 0;
  int   fails  = 0;
  int   busyCount = 0;
  logic prevBusy = 1'b0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .mdctr(mdctr),
    .start(start), .busy(busy), .hi(hi), .lo(lo), .mdout(mdout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue edge is the posedge inside this task; returns #1 after it.
  task automatic applyStimulus(input md_op_e op, input logic [31:0] a,
                               input logic [31:0] b);
    mdctr = op;
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mdctr = MD_NONE;
  endtask

  task automatic pushExp(input string name, input logic [31:0] h,
                         input logic [31:0] l, input int n);
    exp_t e;
    e.name   = name;
    e.hi     = h;
    e.lo     = l;
    e.cycles = n;
    sbQueue.push_back(e);
  endtask

  task automatic waitIdle(input string name);
    bit done = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy && sbQueue.size() == 0) begin
        done = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s_timeout: got busy=%0b pending=%0d expected idle", name, busy, sbQueue.size());
    end
  endtask

  // Monitor: counts busy cycles and checks the committed result on busy's fall.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busyCount = 0;
      prevBusy  = 1'b0;
    end else begin
      if (busy === 1'b1) begin
        busyCount++;
      end else if (prevBusy) begin
        if (sbQueue.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_commit: got hi=%h lo=%h expected no commit", hi, lo);
        end else begin
          e = sbQueue.pop_front();
          checkOutput({e.name, "_hi"}, hi, e.hi);
          checkOutput({e.name, "_lo"}, lo, e.lo);
          checkOutput({e.name, "_busycycles"}, 32'(busyCount), 32'(e.cycles));
        end
        busyCount = 0;
      end
      prevBusy = busy;
    end
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    mdctr = MD_NONE;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);

    pushExp("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    applyStimulus(MD_MULT, 32'hFFFFFFFE, 32'd3);
    waitIdle("mult");

    pushExp("multu", 32'h00000002, 32'hFFFFFFFA, 5);
    applyStimulus(MD_MULTU, 32'hFFFFFFFE, 32'd3);
    waitIdle("multu");

    pushExp("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    applyStimulus(MD_DIV, 32'hFFFFFFF9, 32'd2);
    waitIdle("div");

    pushExp("divu", 32'd1, 32'd3, 10);
    applyStimulus(MD_DIVU, 32'd7, 32'd2);
    waitIdle("divu");

    applyStimulus(MD_MTHI, 32'h12345678, 32'd0);
    checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
    mdctr = MD_MFLO;
    #1;
    checkOutput("mflo", mdout, 32'd3);
    mdctr = MD_MFHI;
    #1;
    checkOutput("mfhi", mdout, 32'h12345678);
    mdctr = MD_NONE;
    #1;
    checkOutput("mdout_none", mdout, 32'd0);

    pushExp("divu_zero", 32'h12345678, 32'd3, 10);
    applyStimulus(MD_DIVU, 32'd5, 32'd0);
    waitIdle("divu_zero");

    pushExp("mult_ignore", 32'd0, 32'd6, 5);
    applyStimulus(MD_MULT, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    applyStimulus(MD_MULT, 32'd7, 32'd7);
    waitIdle("mult_ignore");

    pushExp("div_ovf", 32'd0, 32'h80000000, 10);
    applyStimulus(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitIdle("div_ovf");

    mdctr = MD_MTHI;
    A     = 32'hDEADBEEF;
    start = 1'b0;
    @(posedge clk);
    #1;
    mdctr = MD_NONE;
    checkOutput("nostart_mthi", hi, 32'd0);

    applyStimulus(MD_MTLO, 32'hCAFEF00D, 32'd0);
    checkOutput("mtlo", lo, 32'hCAFEF00D);

    applyStimulus(MD_MULT, 32'd5, 32'd5);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("abort_nocommit_lo", lo, 32'd0);
    checkOutput("abort_nocommit_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
